logic_unit_pipe: RTL and testbench

- Parametrised, registered successor of our two-input gate block.
- Applies one of eight bitwise logic operations (AND, OR, NOT, BUF, NAND, NOR, XOR, XNOR) to WIDTH-bit operands.
- Carries results through a STAGES-deep valid/ready pipeline with full backpressure and adds status flags.
- Sits between operand producers and the datapath that consumes logic results.

---
 rtl/logic_unit_pkg.sv | 41 ++++
 rtl/logic_unit_pipe_stage.sv | 46 ++++
 rtl/logic_unit_pipe.sv | 110 +++++++++++
 tb/tb_logic_unit_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared types and helpers for the logic unit pipeline.
// Op encoding, counter width and a width-generic bitwise evaluator.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_BUF  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XOR  = 3'd6,
    OP_XNOR = 3'd7
  } logic_op_t;

  localparam int OP_COUNT_W = 16;
  localparam int EVAL_W     = 64;

  // Evaluated at full width; callers truncate to their own WIDTH.
  function automatic logic [EVAL_W-1:0] logic_eval(
    input logic [EVAL_W-1:0] a,
    input logic [EVAL_W-1:0] b,
    input logic_op_t         op
  );
    logic [EVAL_W-1:0] r;
    r = '0;
    unique case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_BUF:  r = a;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_pipe_stage.sv
// logic_pipe_stage: one valid/ready register slot holding {valid, y}.
// Ports: in_valid/in_ready/in_y upstream, out_valid/out_ready/out_y downstream.
module logic_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] y_q, y_d;

  // Slot can take a beat when empty or when its content leaves now.
  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    y_d     = y_q;
    if (in_ready) begin
      valid_d = in_valid;
    end
    if (in_ready && in_valid) begin
      y_d = in_y;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      y_q     <= '0;
    end else begin
      valid_q <= valid_d;
      y_q     <= y_d;
    end
  end

  assign out_valid = valid_q;
  assign out_y     = y_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: bitwise op unit feeding a STAGES-deep valid/ready pipe.
// Ports: in_* operand beat, out_* result beat + flags, op_count accepts.
// Macro LOGIC_UNIT_PARITY_EN adds out_parity (XOR-reduce of out_y).
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  input  logic [2:0]            in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_y,
  output logic                  out_zero,
  output logic                  out_ones,
`ifdef LOGIC_UNIT_PARITY_EN
  output logic                  out_parity,
`endif
  output logic [OP_COUNT_W-1:0] op_count
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("logic_unit_pipe: WIDTH %0d out of 1..64", WIDTH);
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("logic_unit_pipe: STAGES %0d out of 1..4", STAGES);
  end

  // Index k is the link into stage k; index STAGES is the output.
  logic             v_s [STAGES+1];
  logic             r_s [STAGES+1];
  logic [WIDTH-1:0] y_s [STAGES+1];

  assign v_s[0] = in_valid;
  assign y_s[0] = WIDTH'(logic_eval(EVAL_W'(in_a), EVAL_W'(in_b),
                                    logic_op_t'(in_op)));
  assign r_s[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v_s[k]),
      .in_ready  (r_s[k]),
      .in_y      (y_s[k]),
      .out_valid (v_s[k+1]),
      .out_ready (r_s[k+1]),
      .out_y     (y_s[k+1])
    );
  end

  assign in_ready  = r_s[0];
  assign out_valid = v_s[STAGES];
  assign out_y     = y_s[STAGES];

  // Flags only assert alongside a live beat, so they read 0 out of reset.
  assign out_zero = out_valid && (out_y == '0);
  assign out_ones = out_valid && (&out_y);

  logic [OP_COUNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && in_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign op_count = cnt_q;

`ifdef LOGIC_UNIT_PARITY_EN
  logic par_q, par_d;
  logic last_load;

  // Parity is captured with the same load that fills the last slot.
  assign last_load = v_s[STAGES-1] && r_s[STAGES-1];

  always_comb begin
    par_d = par_q;
    if (last_load) begin
      par_d = ^y_s[STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign out_parity = par_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH=8, STAGES=3).
// Random and directed beats are scored against a queue-based model.
module tb_logic_unit_pipe;

  localparam int W = 8;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2:0]   in_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_y;
  logic         out_zero;
  logic         out_ones;
  logic [15:0]  op_count;
`ifdef LOGIC_UNIT_PARITY_EN
  logic         out_parity;
`endif

  logic_unit_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_zero   (out_zero),
    .out_ones   (out_ones),
`ifdef LOGIC_UNIT_PARITY_EN
    .out_parity (out_parity),
`endif
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  int     n_chk = 0;
  int     n_err = 0;
  longint cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input int op);
    case (op)
      0:       return a & b;
      1:       return a | b;
      2:       return ~a;
      3:       return a;
      4:       return ~(a & b);
      5:       return ~(a | b);
      6:       return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  typedef struct {
    logic [W-1:0] y;
    longint       t;
  } beat_t;

  beat_t        q[$];
  logic [15:0]  mcnt = '0;
  bit           lat_chk = 1'b0;
  int           n_lat = 0;
  bit           hold_v = 1'b0;
  logic [W-1:0] hold_y;

  // Model: accepted beats queue up; pipeline has S slots that collapse
  // bubbles, so a beat can enter whenever a slot is free or one leaves.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mcnt   = '0;
      hold_v = 1'b0;
    end else begin
      chk("in_ready", in_ready, (q.size() < S) || out_ready);
      chk("op_count", op_count, mcnt);
      if (hold_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_y", out_y, hold_y);
      end
      hold_v = out_valid && !out_ready;
      hold_y = out_y;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_beat", 1, 0);
        end else begin
          chk("zero", out_zero, q[0].y == '0);
          chk("ones", out_ones, q[0].y == '1);
`ifdef LOGIC_UNIT_PARITY_EN
          chk("parity", out_parity, ^q[0].y);
`endif
          if (out_ready) begin
            chk("out_y", out_y, q[0].y);
            if (lat_chk) begin
              chk("latency", cyc - q[0].t, S);
              n_lat++;
            end
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{y: ref_op(in_a, in_b, int'(in_op)), t: cyc});
        mcnt = mcnt + 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_in();
    in_a  = W'($urandom);
    in_b  = W'($urandom);
    in_op = 3'($urandom_range(0, 7));
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op);
    int n = 0;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 100) begin
        chk("out_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (S + 10) step();
    chk("drained", q.size(), 0);
  endtask

  logic [7:0] tbl [8];

  initial begin
    tbl = '{8'hC0, 8'hFC, 8'h0F, 8'hF0, 8'h3F, 8'h03, 8'h3C, 8'hC3};

    step();
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_ones", out_ones, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef LOGIC_UNIT_PARITY_EN
    chk("rst_parity", out_parity, 0);
`endif

    // Op sweep, one beat at a time.
    out_ready = 1'b1;
    for (int op = 0; op < 8; op++) begin
      send(8'hF0, 8'hCC, 3'(op));
      wait_out();
      chk("sweep_y", out_y, tbl[op]);
      step();
    end
    chk("sweep_count", op_count, 8);

    // Back-to-back stream, latency checked per beat.
    lat_chk = 1'b1;
    n_lat   = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rnd_in();
      step();
    end
    in_valid = 1'b0;
    repeat (S + 3) step();
    lat_chk = 1'b0;
    chk("stream_beats", n_lat, 5);

    // Backpressure: fill, stall four cycles, release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < S + 2; i++) begin
      rnd_in();
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_occupancy", q.size(), S);
    drain();

    // Flags.
    send(8'hFF, 8'hFF, 3'd6);
    wait_out();
    chk("flag_zero", out_zero, 1);
    step();
    send(8'hFF, 8'hFF, 3'd0);
    wait_out();
    chk("flag_ones", out_ones, 1);
    step();
    send(8'h07, 8'h00, 3'd3);
    wait_out();
    chk("buf_y", out_y, 8'h07);
`ifdef LOGIC_UNIT_PARITY_EN
    chk("flag_parity", out_parity, 1);
`endif
    step();
    drain();

    // Reset with two beats in flight and a beat offered during reset.
    out_ready = 1'b0;
    send(8'h12, 8'h34, 3'd6);
    send(8'h56, 8'h78, 3'd1);
    chk("inflight", q.size(), 2);
    rnd_in();
    in_valid = 1'b1;
    rst_n    = 1'b0;
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", op_count, 0);
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (S + 6) step();
    chk("post_rst_count", op_count, 0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rnd_in();
      step();
    end
    drain();

    // Counter wrap.
    do_reset();
    out_ready = 1'b1;
    rnd_in();
    in_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("wrap_pre", op_count, 16'hFFFF);
    send(8'hAA, 8'h55, 3'd7);
    chk("wrap", op_count, 16'h0000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
